// File: rtl/operand_register_file.sv
// ALU operand stage: eight WIDTH-bit registers (R1-R4, S1-S4), per-cycle FunSel ops, two read muxes.
// Optional macro REGFILE_BYPASS_EN: buses show the value a selected register takes at the coming edge.
module operand_register_file #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       reg_en;

  // Index 0..7 matches the read-select encoding: R1..R4 then S1..S4.
  assign reg_en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
                   RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

  function automatic logic [WIDTH-1:0] next_val(input logic [2:0]       fun,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] result;
    result = q;
    case (fun)
      3'b000:  result = q - WIDTH'(1);
      3'b001:  result = q + WIDTH'(1);
      3'b010:  result = din;
      3'b011:  result = '0;
      3'b100:  result = {{HALF{1'b0}}, din[HALF-1:0]};
      3'b101:  result = {q[WIDTH-1:HALF], din[HALF-1:0]};
      3'b110:  result = {din[HALF-1:0], q[HALF-1:0]};
      3'b111:  result = {{HALF{din[HALF-1]}}, din[HALF-1:0]};
      default: result = q;
    endcase
    return result;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = reg_en[i] ? next_val(FunSel, regs_q[i], I) : regs_q[i];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // regs_d already equals Q for unselected registers; the next value is not cleared by Reset, so gate it.
  assign OutA = Reset ? '0 : regs_d[OutASel];
  assign OutB = Reset ? '0 : regs_d[OutBSel];
`else
  assign OutA = regs_q[OutASel];
  assign OutB = regs_q[OutBSel];
`endif

endmodule

// File: tb/tb_operand_register_file.sv
// Directed self-checking bench for operand_register_file; expectations are hand-computed constants.
module tb_operand_register_file;

  logic        Clock;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int checks;
  int failures;

  operand_register_file #(.WIDTH(32)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .I      (I),
    .FunSel (FunSel),
    .RegSel (RegSel),
    .ScrSel (ScrSel),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Apply one operation for a single edge, then drop all enables.
  task automatic apply_op(input logic [2:0] f, input logic [3:0] rsel,
                          input logic [3:0] ssel, input logic [31:0] data);
    FunSel = f;
    RegSel = rsel;
    ScrSel = ssel;
    I      = data;
    tick();
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
  endtask

  // Load register idx (0..3 = R1..R4, 4..7 = S1..S4) with a value.
  task automatic load_reg(input int idx, input logic [31:0] value);
    logic [7:0] onehot;
    onehot = 8'b0000_0001 << idx;
    apply_op(3'b010, {onehot[0], onehot[1], onehot[2], onehot[3]},
             {onehot[4], onehot[5], onehot[6], onehot[7]}, value);
  endtask

  task automatic test_reset();
    Reset = 1'b1; I = '0; FunSel = '0; RegSel = '0; ScrSel = '0;
    OutASel = 3'b000; OutBSel = 3'b111;
    #3;
    checks++;
    if (OutA !== 32'h0 || OutB !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_initial OutA=%h OutB=%h expected 0", OutA, OutB);
    end
    tick();
    Reset = 1'b0;
    load_reg(0, 32'h1234_5678);
    OutASel = 3'b000;
    #1;
    checks++;
    if (OutA !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL load_r1 OutA=%h expected 12345678", OutA);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (OutA !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_reset OutA=%h expected 0", OutA);
    end
    FunSel = 3'b010; RegSel = 4'b1111; ScrSel = 4'b1111; I = 32'hDEAD_BEEF;
    tick();
    tick();
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(7 - s);
      #1;
      checks++;
      if (OutA !== 32'h0 || OutB !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold sel=%0d OutA=%h OutB=%h expected 0", s, OutA, OutB);
      end
    end
    RegSel = '0; ScrSel = '0;
    Reset = 1'b0;
    #1;
    OutASel = 3'b000;
    #1;
    checks++;
    if (OutA !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_release OutA=%h expected 0", OutA);
    end
  endtask

  task automatic test_wrap();
    OutBSel = 3'b101;
    apply_op(3'b011, 4'b0000, 4'b0100, 32'h0);
    apply_op(3'b000, 4'b0000, 4'b0100, 32'h0);
    checks++;
    if (OutB !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL wrap_dec OutB=%h expected ffffffff", OutB);
    end
    apply_op(3'b001, 4'b0000, 4'b0100, 32'h0);
    checks++;
    if (OutB !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wrap_inc OutB=%h expected 00000000", OutB);
    end
  endtask

  task automatic test_half_word();
    logic [2:0]  funs [4];
    logic [31:0] data [4];
    logic [31:0] exps [4];
    funs = '{3'b101, 3'b110, 3'b111, 3'b100};
    data = '{32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_8001, 32'hFFFF_8001};
    exps = '{32'hAAAA_BEEF, 32'hBEEF_BEEF, 32'hFFFF_8001, 32'h0000_8001};
    OutASel = 3'b010;
    load_reg(2, 32'hAAAA_5555);
    for (int k = 0; k < 4; k++) begin
      apply_op(funs[k], 4'b0010, 4'b0000, data[k]);
      checks++;
      if (OutA !== exps[k]) begin
        failures++;
        $display("[TB] FAIL half_word fun=%b OutA=%h expected %h", funs[k], OutA, exps[k]);
      end
    end
  endtask

  task automatic test_multi_select();
    logic [31:0] exps [8];
    load_reg(0, 32'd5);
    load_reg(1, 32'd9);
    load_reg(2, 32'h33);
    load_reg(3, 32'h44);
    load_reg(4, 32'h55);
    load_reg(7, 32'hFFFF_FFFF);
    apply_op(3'b001, 4'b1100, 4'b0001, 32'h0);
    apply_op(3'b011, 4'b0000, 4'b0000, 32'h0);
    exps = '{32'd6, 32'd10, 32'h33, 32'h44, 32'h55, 32'h0, 32'h0, 32'h0};
    for (int s = 0; s < 8; s++) begin
      if (s == 5 || s == 6) continue;
      OutASel = 3'(s);
      OutBSel = 3'(s);
      #1;
      checks++;
      if (OutA !== exps[s] || OutB !== exps[s]) begin
        failures++;
        $display("[TB] FAIL multi_select sel=%0d OutA=%h OutB=%h expected %h", s, OutA, OutB, exps[s]);
      end
    end
  endtask

  task automatic test_read_timing();
    logic [31:0] exp_pre;
    load_reg(2, 32'd7);
    OutASel = 3'b010;
    OutBSel = 3'b010;
    FunSel = 3'b010;
    RegSel = 4'b0010;
    ScrSel = 4'b0000;
    I = 32'h42;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h42;
`else
    exp_pre = 32'd7;
`endif
    #2;
    checks++;
    if (OutA !== exp_pre || OutB !== exp_pre) begin
      failures++;
      $display("[TB] FAIL read_pre_edge OutA=%h OutB=%h expected %h", OutA, OutB, exp_pre);
    end
    tick();
    RegSel = 4'b0000;
    #1;
    checks++;
    if (OutA !== 32'h42 || OutB !== 32'h42) begin
      failures++;
      $display("[TB] FAIL read_post_edge OutA=%h OutB=%h expected 00000042", OutA, OutB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exps [3];
    exps = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    load_reg(3, 32'hFFFF_FFFE);
    OutASel = 3'b011;
    for (int k = 0; k < 3; k++) begin
      apply_op(3'b001, 4'b0001, 4'b0000, 32'h0);
      checks++;
      if (OutA !== exps[k]) begin
        failures++;
        $display("[TB] FAIL back_to_back step=%0d OutA=%h expected %h", k, OutA, exps[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_wrap();
    test_half_word();
    test_multi_select();
    test_read_timing();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_register_file.md
Name: operand_register_file

Overview:
- Upstream operand stage for the ALU.
- Holds four 32-bit general registers (R1-R4) and four 32-bit scratch registers (S1-S4).
- Applies a per-cycle register operation to any subset of them.
- Drives the ALU A and B operand buses through two independent read muxes.
- Input I carries the ALU result or memory/IR data on writeback.

Parameters:
- WIDTH, 32, register and bus width in bits; must be even, minimum 16.
- HALF, WIDTH/2, width of the low/high half-word fields used by FunSel 100-111.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; clears all eight registers.
- I  input  WIDTH  write data.
- FunSel  input  3  operation applied to every selected register.
- RegSel  input  4  general-register enables, active-high; bit3=R1, bit2=R2, bit1=R3, bit0=R4.
- ScrSel  input  4  scratch-register enables, active-high; bit3=S1, bit2=S2, bit1=S3, bit0=S4.
- OutASel  input  3  A-bus source: 000..011 = R1..R4, 100..111 = S1..S4.
- OutBSel  input  3  B-bus source, same encoding as OutASel.
- OutA  output  WIDTH  operand A to the ALU.
- OutB  output  WIDTH  operand B to the ALU.

Behaviour:
- Reset asserted at any time, including mid-operation: all registers become 0 immediately, without waiting for a clock edge. OutA and OutB therefore read 0.
- While Reset is high, clock edges have no effect.
- The first update happens on the first rising Clock edge after Reset deasserts.
- Each rising edge updates every register whose enable bit is 1. Registers with enable 0 hold their value.
- An all-zero RegSel and ScrSel is a legal no-op.
- FunSel encoding (Q = current value, Q' = next value):
  - 000: Q' = Q - 1, modulo 2^WIDTH; 0 wraps to all-ones.
  - 001: Q' = Q + 1, modulo 2^WIDTH; all-ones wraps to 0.
  - 010: Q' = I.
  - 011: Q' = 0.
  - 100: Q' = {0, I[HALF-1:0]}.
  - 101: Q' = {Q[WIDTH-1:HALF], I[HALF-1:0]}.
  - 110: Q' = {I[HALF-1:0], Q[HALF-1:0]}.
  - 111: Q' = sign-extension of I[HALF-1:0].
- Multiple enables in one cycle: all selected registers take the same FunSel, each computed from its own Q. Increment or decrement on several registers is independent per register.
- Read path:
  - OutA and OutB are combinational muxes of the current register values, no latency.
  - A register written at edge n is visible on OutA/OutB after edge n, not before. No internal forwarding unless the optional feature is enabled.
  - OutASel and OutBSel may select the same register; both buses then carry the same value.
  - Reading a register that is being written this cycle returns its pre-edge value.
- All selector inputs are fully decoded; no illegal codes and no X propagation from valid inputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If the register selected by OutASel or OutBSel has its enable set this cycle, that bus shows Q' (the value it will hold after the coming edge) combinationally instead of Q.
  - Gives same-cycle read-after-write for single-cycle ALU loops.
  - Reset still forces both outputs to 0.
- Undefined: behaviour exactly as in the Read path above; no bypass logic is synthesised.

Test Plan:
- Reset and clock:
  - Load R1=0x12345678, then assert Reset between clock edges → OutA (OutASel=000) is 0 before the next edge.
  - Hold Reset high across two edges with RegSel=1111 and FunSel=010 → all registers remain 0.
- Wrap-around:
  - Clear S2, then FunSel=000 with ScrSel=0100 → OutB (OutBSel=101) = 0xFFFFFFFF.
  - Then FunSel=001 → OutB = 0x00000000.
- Half-word ops:
  - R3=0xAAAA5555, I=0x0000BEEF:
    - FunSel=101 → 0xAAAABEEF.
    - Then FunSel=110 → 0xBEEFBEEF.
  - Then FunSel=111 with I=0x00008001 → 0xFFFF8001.
  - Then FunSel=100 with I=0xFFFF8001 → 0x00008001.
- Multi-select increment: R1=5, R2=9, S4=0xFFFFFFFF, RegSel=1100, ScrSel=0001, FunSel=001 → R1=6, R2=10, S4=0; R3 and R4 unchanged.
- Read timing: OutASel=OutBSel=010 with R3=7, then load R3=I=0x42 → both buses show 7 until the edge and 0x42 after it.
  - With REGFILE_BYPASS_EN defined, both buses show 0x42 during the load cycle, before the edge.
